// File: rtl/codma_mem_pkg.sv
// rtl/codma_mem_pkg.sv - shared types and helpers for the codma memory slave
// Contents: size_e burst-size encoding, beats() size-to-beat-count helper,
//           slave_state_e FSM states, DW_BYTES bytes per 64-bit double-word.
package codma_mem_pkg;

  localparam int unsigned DW_BYTES = 8;

  typedef enum logic [3:0] {
    SIZE_1DW = 4'd0,
    SIZE_2DW = 4'd1,
    SIZE_4DW = 4'd2
  } size_e;

  typedef enum logic [2:0] {
    IDLE,
    ADDR_WAIT,
    GRANT,
    ERR,
    RD_WAIT,
    RD_DATA,
    WR_DATA
  } slave_state_e;

  // Unsupported encodings map to 1 beat; they are rejected before any access.
  function automatic logic [2:0] beats(input size_e s);
    case (s)
      SIZE_2DW: return 3'd2;
      SIZE_4DW: return 3'd4;
      default:  return 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/mem_interface.sv
// rtl/mem_interface.sv - codma memory bus between DMA master and memory slave
// Signals: read/write request strobes, addr[31:0] byte address, size[3:0] burst
//          size, write_data[63:0]/write_valid write beats; grant, read_data[63:0],
//          read_valid, error returned by the slave.
interface mem_interface;
  logic        read;
  logic        write;
  logic [31:0] addr;
  logic [3:0]  size;
  logic [63:0] write_data;
  logic        write_valid;
  logic        grant;
  logic [63:0] read_data;
  logic        read_valid;
  logic        error;

  modport master (
    output read, write, addr, size, write_data, write_valid,
    input  grant, read_data, read_valid, error
  );

  modport slave (
    input  read, write, addr, size, write_data, write_valid,
    output grant, read_data, read_valid, error
  );
endinterface

// File: rtl/codma_sram.sv
// rtl/codma_sram.sv - single-port synchronous 64-bit RAM, 1-cycle read, no reset
// Ports: i_clk clock; i_en access enable; i_we write enable (else read);
//        i_addr word address; i_wdata write word; o_rdata registered read word.
module codma_sram #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = 10
) (
  input  logic          i_clk,
  input  logic          i_en,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [63:0]   i_wdata,
  output logic [63:0]   o_rdata
);

  logic [63:0] r_mem [DEPTH];
  logic [63:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_en) begin
      if (i_we) begin
        r_mem[i_addr] <= i_wdata;
      end else begin
        r_rdata <= r_mem[i_addr];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/codma_mem_slave.sv
// rtl/codma_mem_slave.sv - memory-backed slave on the codma memory bus
// Ports: clk rising-edge clock; rst_n asynchronous active-low reset;
//        mem slave modport (requests/write beats in, grant/read data/error out).
module codma_mem_slave
  import codma_mem_pkg::*;
#(
  parameter int unsigned MEM_DEPTH_DW  = 1024,
  parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
  parameter int unsigned GRANT_LATENCY = 1,
  parameter int unsigned READ_LATENCY  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  mem_interface.slave mem
);

  localparam int unsigned AW = (MEM_DEPTH_DW > 1) ? $clog2(MEM_DEPTH_DW) : 1;
  localparam int unsigned SH = $clog2(DW_BYTES);

  slave_state_e r_state, w_next;

  logic                    r_rd, r_wr;
  logic [31:0]             r_addr;
  logic [3:0]              r_size;
  logic [31:0]             r_cnt;
  logic [2:0]              r_beat;
  logic [AW-1:0]           r_wr_ptr;
  logic [AW-1:0]           r_rd_ptr;
  logic [2:0]              r_iss_left;
  logic                    r_q_vld;
  logic [READ_LATENCY-1:0] r_pipe_vld;
  logic [READ_LATENCY-1:0][63:0] r_pipe_data;
  logic                    r_grant, r_error;

  logic          w_req, w_err, w_size_ok, w_wait_done, w_rd_wait_done;
  logic          w_grant_d, w_error_d, w_wr_beat, w_iss_first, w_iss;
  logic [2:0]    w_n;
  logic [32:0]   w_sub;
  logic [31:0]   w_diff;
  logic [32:0]   w_end;
  logic [AW-1:0] w_offset, w_iss_addr, w_sram_addr;
  logic          w_sram_en;
  logic [63:0]   w_sram_q;

  // Request decode and range check on the latched request. The 33-bit
  // subtraction exposes addr < BASE_ADDR as a borrow, and the end-of-burst sum
  // is also 33 bits so it cannot wrap.
  always_comb begin
    w_req       = (r_state == IDLE) && (mem.read || mem.write);
    w_size_ok   = r_size inside {SIZE_1DW, SIZE_2DW, SIZE_4DW};
    w_n         = beats(size_e'(r_size));
    w_sub       = {1'b0, r_addr} - {1'b0, BASE_ADDR};
    w_diff      = w_sub[31:0];
    w_end       = ({1'b0, w_diff} >> SH) + 33'(w_n);
    w_offset    = w_diff[AW+SH-1:SH];
    w_err       = (r_rd && r_wr) || !w_size_ok || (r_addr[2:0] != 3'd0) ||
                  w_sub[32] || (w_end > 33'(MEM_DEPTH_DW));
    w_wait_done    = (r_state == ADDR_WAIT) && (r_cnt == GRANT_LATENCY - 1);
    w_rd_wait_done = (r_cnt == READ_LATENCY - 2);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      if (w_req) w_next = ADDR_WAIT;
      ADDR_WAIT: if (w_wait_done) w_next = GRANT;
      GRANT: begin
        if (w_err)                   w_next = ERR;
        else if (!r_rd)              w_next = WR_DATA;
        else if (READ_LATENCY == 1)  w_next = RD_DATA;
        else                         w_next = RD_WAIT;
      end
      ERR:       w_next = IDLE;
      RD_WAIT:   if (w_rd_wait_done) w_next = RD_DATA;
      RD_DATA:   if (r_beat == w_n - 3'd1) w_next = IDLE;
      WR_DATA:   if (w_wr_beat && (r_beat == w_n - 3'd1)) w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end

  // Output / datapath control. Reads are issued to the RAM from the last
  // ADDR_WAIT cycle so the RAM stage plus READ_LATENCY pipeline stages line the
  // first beat up with grant+READ_LATENCY; the issue is suppressed on error.
  always_comb begin
    w_grant_d   = (w_next == GRANT);
    w_error_d   = (w_next == ERR);
    w_wr_beat   = (r_state == WR_DATA) && mem.write_valid;
    w_iss_first = w_wait_done && r_rd && !w_err;
    w_iss       = w_iss_first || (r_iss_left != 3'd0);
    w_iss_addr  = w_iss_first ? w_offset : r_rd_ptr;
    w_sram_en   = w_iss || w_wr_beat;
    w_sram_addr = w_wr_beat ? r_wr_ptr : w_iss_addr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd       <= 1'b0;
      r_wr       <= 1'b0;
      r_addr     <= '0;
      r_size     <= '0;
      r_cnt      <= '0;
      r_beat     <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_iss_left <= '0;
      r_grant    <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      if (w_req) begin
        r_rd   <= mem.read;
        r_wr   <= mem.write;
        r_addr <= mem.addr;
        r_size <= mem.size;
      end

      if (w_next != r_state) begin
        r_cnt <= '0;
      end else if ((r_state == ADDR_WAIT) || (r_state == RD_WAIT)) begin
        r_cnt <= r_cnt + 32'd1;
      end

      if (w_next != r_state) begin
        r_beat <= '0;
      end else if ((r_state == RD_DATA) || w_wr_beat) begin
        r_beat <= r_beat + 3'd1;
      end

      if (r_state == GRANT) begin
        r_wr_ptr <= w_offset;
      end else if (w_wr_beat) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end

      if (w_iss_first) begin
        r_rd_ptr   <= w_offset + AW'(1);
        r_iss_left <= w_n - 3'd1;
      end else if (r_iss_left != 3'd0) begin
        r_rd_ptr   <= r_rd_ptr + AW'(1);
        r_iss_left <= r_iss_left - 3'd1;
      end

      r_grant <= w_grant_d;
      r_error <= w_error_d;
    end
  end

  // Read return pipeline; data is zeroed at entry so read_data is 0 whenever
  // read_valid is 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q_vld     <= 1'b0;
      r_pipe_vld  <= '0;
      r_pipe_data <= '0;
    end else begin
      r_q_vld        <= w_iss;
      r_pipe_vld[0]  <= r_q_vld;
      r_pipe_data[0] <= r_q_vld ? w_sram_q : 64'd0;
      for (int i = 1; i < int'(READ_LATENCY); i++) begin
        r_pipe_vld[i]  <= r_pipe_vld[i-1];
        r_pipe_data[i] <= r_pipe_data[i-1];
      end
    end
  end

  codma_sram #(
    .DEPTH (MEM_DEPTH_DW),
    .AW    (AW)
  ) u_sram (
    .i_clk   (clk),
    .i_en    (w_sram_en),
    .i_we    (w_wr_beat),
    .i_addr  (w_sram_addr),
    .i_wdata (mem.write_data),
    .o_rdata (w_sram_q)
  );

  assign mem.grant      = r_grant;
  assign mem.error      = r_error;
  assign mem.read_valid = r_pipe_vld[READ_LATENCY-1];
  assign mem.read_data  = r_pipe_data[READ_LATENCY-1];

endmodule

// File: tb/tb_codma_mem_slave.sv
// tb/tb_codma_mem_slave.sv - directed self-checking bench for codma_mem_slave
module tb_codma_mem_slave;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  logic [3:0][63:0] pat;

  mem_interface m0 ();
  mem_interface m1 ();

  codma_mem_slave dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .mem   (m0)
  );

  codma_mem_slave #(
    .GRANT_LATENCY (3),
    .READ_LATENCY  (2)
  ) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .mem   (m1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Request was driven just after a posedge; the next posedge samples it.
  // Returns at the negedge of the grant cycle.
  task automatic gwait0(input int exp_lat, input string tag);
    int n;
    @(posedge clk);
    n = 0;
    @(negedge clk);
    while (m0.grant !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chki({tag, "_grant_lat"}, n, exp_lat);
  endtask

  task automatic gwait1(input int exp_lat, input string tag);
    int n;
    @(posedge clk);
    n = 0;
    @(negedge clk);
    while (m1.grant !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chki({tag, "_grant_lat"}, n, exp_lat);
  endtask

  task automatic req0(input logic rd, input logic wr, input logic [31:0] a,
                      input logic [3:0] s, input string tag);
    @(posedge clk);
    #1;
    m0.read  = rd;
    m0.write = wr;
    m0.addr  = a;
    m0.size  = s;
    gwait0(1, tag);
    m0.read  = 1'b0;
    m0.write = 1'b0;
  endtask

  task automatic rd_beats0(input int n, input logic [3:0][63:0] d, input string tag);
    for (int b = 0; b < n; b++) begin
      @(negedge clk);
      chkb($sformatf("%s_valid%0d", tag, b), m0.read_valid, 1'b1);
      chk($sformatf("%s_data%0d", tag, b), m0.read_data, d[b]);
    end
    @(negedge clk);
    chkb({tag, "_valid_end"}, m0.read_valid, 1'b0);
    chk({tag, "_data_end"}, m0.read_data, 64'd0);
  endtask

  // Starts at the grant-cycle negedge; junk write_valid in the grant cycle
  // must be ignored. gap_at inserts a 2-cycle hole before that beat index.
  task automatic wr_beats0(input int n, input logic [3:0][63:0] d, input int gap_at);
    m0.write_valid = 1'b1;
    m0.write_data  = 64'hBAD0_BAD0_BAD0_BAD0;
    @(posedge clk);
    #1;
    for (int b = 0; b < n; b++) begin
      if (b == gap_at) begin
        m0.write_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
      end
      m0.write_valid = 1'b1;
      m0.write_data  = d[b];
      @(posedge clk);
      #1;
    end
    m0.write_valid = 1'b0;
  endtask

  task automatic err0(input string tag);
    @(negedge clk);
    chkb({tag, "_error"}, m0.error, 1'b1);
    chkb({tag, "_no_valid"}, m0.read_valid, 1'b0);
    @(negedge clk);
    chkb({tag, "_error_clr"}, m0.error, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    m0.read = 1'b0; m0.write = 1'b0; m0.addr = '0; m0.size = '0;
    m0.write_data = '0; m0.write_valid = 1'b0;
    m1.read = 1'b0; m1.write = 1'b0; m1.addr = '0; m1.size = '0;
    m1.write_data = '0; m1.write_valid = 1'b0;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chkb("rst_grant", m0.grant, 1'b0);
    chkb("rst_valid", m0.read_valid, 1'b0);
    chk("rst_data", m0.read_data, 64'd0);
    chkb("rst_error", m0.error, 1'b0);
    chkb("rst1_grant", m1.grant, 1'b0);
    chkb("rst1_valid", m1.read_valid, 1'b0);
    rst_n = 1'b1;

    // Single-beat word 4 at byte 0x20
    pat = {64'd0, 64'd0, 64'd0, 64'hDEAD_BEEF_0123_4567};
    req0(1'b0, 1'b1, 32'h20, 4'd0, "w4");
    wr_beats0(1, pat, -1);
    req0(1'b1, 1'b0, 32'h20, 4'd0, "r4");
    rd_beats0(1, pat, "r4");

    // 4-beat write with a gap after beat 2, then 4-beat read back
    pat = {64'd4, 64'd3, 64'd2, 64'd1};
    req0(1'b0, 1'b1, 32'h40, 4'd2, "w8");
    wr_beats0(4, pat, 2);
    req0(1'b1, 1'b0, 32'h40, 4'd2, "r8");
    rd_beats0(4, pat, "r8");

    // Range / alignment errors
    req0(1'b1, 1'b0, 32'h1FF8, 4'd1, "oor");
    err0("oor");
    req0(1'b1, 1'b0, 32'h1004, 4'd0, "misal");
    err0("misal");

    // Last legal word
    pat = {64'd0, 64'd0, 64'd0, 64'h0000_0077_0000_0077};
    req0(1'b0, 1'b1, 32'h1FF8, 4'd0, "wtop");
    wr_beats0(1, pat, -1);
    req0(1'b1, 1'b0, 32'h1FF8, 4'd0, "rtop");
    rd_beats0(1, pat, "rtop");

    // Unsupported size with write_valid pulsed, then both strobes high
    req0(1'b0, 1'b1, 32'h40, 4'd3, "sz3");
    m0.write_valid = 1'b1;
    m0.write_data  = 64'hEEEE_EEEE_EEEE_EEEE;
    err0("sz3");
    m0.write_valid = 1'b0;
    req0(1'b1, 1'b1, 32'h48, 4'd0, "rdwr");
    err0("rdwr");
    pat = {64'd4, 64'd3, 64'd2, 64'd1};
    req0(1'b1, 1'b0, 32'h40, 4'd2, "rchk");
    rd_beats0(4, pat, "rchk");

    // dut1: GRANT_LATENCY=3, READ_LATENCY=2
    @(posedge clk);
    #1;
    m1.write = 1'b1; m1.addr = 32'h0; m1.size = 4'd1;
    gwait1(3, "l1w");
    m1.write = 1'b0;
    @(posedge clk);
    #1;
    m1.write_valid = 1'b1; m1.write_data = 64'hAAAA_0000_0000_0001;
    @(posedge clk);
    #1;
    m1.write_data = 64'hBBBB_0000_0000_0002;
    @(posedge clk);
    #1;
    m1.write_valid = 1'b0;

    @(posedge clk);
    #1;
    m1.read = 1'b1; m1.addr = 32'h0; m1.size = 4'd1;
    gwait1(3, "l1r");
    // Hold a second request through the burst; it must wait for IDLE.
    m1.addr = 32'h8; m1.size = 4'd0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chkb($sformatf("l1_valid_k%0d", k), m1.read_valid, (k == 2) || (k == 3));
      chk($sformatf("l1_data_k%0d", k), m1.read_data,
          (k == 2) ? 64'hAAAA_0000_0000_0001 :
          (k == 3) ? 64'hBBBB_0000_0000_0002 : 64'd0);
      chkb($sformatf("l1_grant_k%0d", k), m1.grant, k == 8);
    end
    m1.read = 1'b0;
    @(negedge clk);
    chkb("l1_second_v1", m1.read_valid, 1'b0);
    @(negedge clk);
    chkb("l1_second_v2", m1.read_valid, 1'b1);
    chk("l1_second_data", m1.read_data, 64'hBBBB_0000_0000_0002);
    @(negedge clk);
    chkb("l1_second_end", m1.read_valid, 1'b0);

    // Reset during a read burst
    req0(1'b1, 1'b0, 32'h40, 4'd2, "rrst");
    @(negedge clk);
    chk("rrst_beat0", m0.read_data, 64'd1);
    @(negedge clk);
    chk("rrst_beat1", m0.read_data, 64'd2);
    rst_n = 1'b0;
    #1;
    chkb("rrst_valid_clr", m0.read_valid, 1'b0);
    chk("rrst_data_clr", m0.read_data, 64'd0);
    chkb("rrst_grant_clr", m0.grant, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset after write beat 2 of 4
    pat = {64'h13, 64'h12, 64'h11, 64'h10};
    req0(1'b0, 1'b1, 32'h0, 4'd2, "pre");
    wr_beats0(4, pat, -1);
    req0(1'b0, 1'b1, 32'h0, 4'd2, "wrst");
    @(posedge clk);
    #1;
    m0.write_valid = 1'b1; m0.write_data = 64'hA0;
    @(posedge clk);
    #1;
    m0.write_data = 64'hA1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    m0.write_valid = 1'b0;
    #1;
    chkb("wrst_grant", m0.grant, 1'b0);
    chkb("wrst_valid", m0.read_valid, 1'b0);
    chkb("wrst_error", m0.error, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    pat = {64'h13, 64'h12, 64'hA1, 64'hA0};
    req0(1'b1, 1'b0, 32'h0, 4'd2, "rpost");
    rd_beats0(4, pat, "rpost");
    pat = {64'd0, 64'd0, 64'd0, 64'hDEAD_BEEF_0123_4567};
    req0(1'b1, 1'b0, 32'h20, 4'd0, "rpost4");
    rd_beats0(1, pat, "rpost4");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
